// File: rtl/ultrasonic_pkg.sv
// ----------------------------------------------------------------------------
// ultrasonic_pkg
//   Shared types and constants for the ultrasonic sending-unit scheduler.
//   - op_e     : requester opcode (HOLD / INC / DEC / OFF)
//   - state_e  : scheduler FSM states
//   - cmd_t    : latched command (opcode + step count)
//   - clamp_step() : reduces a step so the 12-bit DAC level never wraps
// ----------------------------------------------------------------------------
package ultrasonic_pkg;

  localparam int DAC_W      = 12;
  localparam int AMT_W      = 8;
  localparam int STEP_SHIFT = 4;

  // Highest reachable level: the top 8 bits all ones, low nibble zero.
  localparam logic [DAC_W-1:0] LEVEL_MAX = 12'd4080;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_OFF  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_HOLD = 2'd1,
    S_STEP = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [AMT_W-1:0] amount;
  } cmd_t;

  // Effective step count for INC/DEC. The level is always a multiple of 16,
  // so the remaining head/foot room in steps is simply the upper byte of the
  // room in LSBs. Non-stepping opcodes produce zero.
  function automatic logic [AMT_W-1:0] clamp_step(
    input op_e              op,
    input logic [DAC_W-1:0] level,
    input logic [AMT_W-1:0] amount
  );
    logic [DAC_W-1:0] room;
    logic [AMT_W-1:0] limit;
    room  = (op == OP_INC) ? (LEVEL_MAX - level) : level;
    limit = room[DAC_W-1:STEP_SHIFT];
    if (op != OP_INC && op != OP_DEC) begin
      return '0;
    end
    return (amount < limit) ? amount : limit;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search: the winner is the first asserted
//   request at or after i_ptr, wrapping modulo NREQ. NREQ must be >= 2.
//
//   i_valid  [NREQ] request vector
//   i_ptr    [IW]   search start index (must be < NREQ)
//   i_enable        when low, nothing is granted
//   o_grant  [NREQ] one-hot grant
//   o_index  [IW]   index of the granted request
//   o_found         a grant was issued this cycle
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int  NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_index,
  output logic            o_found
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  // NOTE: every signal driven here gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin : search
    logic [IW:0] w_pos;
    o_grant = '0;
    o_index = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr + k can exceed NREQ-1 before the wrap.
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= NREQ_W) begin
        w_pos = w_pos - NREQ_W;
      end
      if (!o_found && i_enable && i_valid[w_pos[IW-1:0]]) begin
        o_found                 = 1'b1;
        o_grant[w_pos[IW-1:0]] = 1'b1;
        o_index                 = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/send_scheduler.sv
// ----------------------------------------------------------------------------
// send_scheduler
//   Collects step commands from NREQ requesters, arbitrates round-robin and
//   drives the ultrasonic sending unit. Keeps a shadow of the 12-bit DAC
//   level, clamps every step so the DAC never wraps, and emits the
//   continuous hold beat that keeps the DAC output alive while level > 0.
//
//   clk, rst            clock, synchronous active-high reset
//   req_valid [NREQ]    requester has a command (op/amount held stable)
//   req_op    [2*NREQ]  per-requester opcode (op_e)
//   req_amount[8*NREQ]  per-requester step count, 16 LSB per step
//   req_ready [NREQ]    one-hot accept pulse
//   estop               emergency stop (drops level, blocks acceptance)
//   order_full          downstream queue full (drops level, blocks accept)
//   order               sending-unit acknowledge, sampled in S_ACK
//   send_enable .. decrease_signal   sending-unit control strobes
//   amount_signal [8]   clamped step count of the current step beat
//   level [12]          shadow DAC level
//   grant_id            index of the last accepted requester
//   clamped             pulse: current step was reduced
//   err_drop            pulse, cycle after the level was lost
// ----------------------------------------------------------------------------
module send_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ACK_TIMEOUT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [AMT_W*NREQ-1:0]   req_amount,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    estop,
  input  logic                    order_full,
  input  logic                    order,
  output logic                    send_enable,
  output logic                    valid_signal,
  output logic                    on_signal,
  output logic                    off_signal,
  output logic                    increase_signal,
  output logic                    decrease_signal,
  output logic [AMT_W-1:0]        amount_signal,
  output logic [DAC_W-1:0]        level,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    clamped,
  output logic                    err_drop
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

  state_e           r_state;
  state_e           w_state_next;
  cmd_t             r_cmd;
  cmd_t             w_sel_cmd;
  logic [DAC_W-1:0] r_level;
  logic [DAC_W-1:0] w_level_next;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_grant_id;
  logic [AW-1:0]    r_ack_cnt;
  logic [AW-1:0]    w_ack_cnt_next;
  logic             r_err_drop;
  logic             w_drop;

  logic             w_override;
  logic             w_accept_en;
  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_index;
  logic             w_found;
  logic [AMT_W-1:0] w_a_eff;
  logic [DAC_W-1:0] w_step;

  // estop and order_full share one path: both drop the level when a beat is
  // running and both merely block acceptance when the unit is already off.
  assign w_override  = estop | order_full;
  assign w_accept_en = ((r_state == S_OFF) || (r_state == S_HOLD)) && !w_override;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_valid  (req_valid),
    .i_ptr    (r_rr_ptr),
    .i_enable (w_accept_en),
    .o_grant  (w_grant),
    .o_index  (w_index),
    .o_found  (w_found)
  );

  // Mux the winning requester's command out of the packed port vectors.
  always_comb begin : pick
    w_sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_cmd.op     = op_e'(req_op[2*i +: 2]);
        w_sel_cmd.amount = req_amount[AMT_W*i +: AMT_W];
      end
    end
  end

  // The level does not move between acceptance and the step beat, so the
  // clamp can be evaluated against the live level during S_STEP.
  assign w_a_eff = clamp_step(r_cmd.op, r_level, r_cmd.amount);
  assign w_step  = {w_a_eff, {STEP_SHIFT{1'b0}}};

  always_comb begin : fsm_next
    w_state_next    = r_state;
    w_level_next    = r_level;
    w_ack_cnt_next  = r_ack_cnt;
    w_drop          = 1'b0;
    send_enable     = 1'b0;
    valid_signal    = 1'b0;
    on_signal       = 1'b0;
    off_signal      = 1'b0;
    increase_signal = 1'b0;
    decrease_signal = 1'b0;
    amount_signal   = '0;
    clamped         = 1'b0;

    case (r_state)
      S_OFF: begin
        // HOLD/DEC/OFF on a dark unit are accepted and dropped silently.
        if (w_found && w_sel_cmd.op == OP_INC) begin
          w_state_next = S_STEP;
        end
      end

      S_HOLD: begin
        send_enable  = 1'b1;
        valid_signal = 1'b1;
        on_signal    = 1'b1;
        if (w_override) begin
          w_drop = 1'b1;
        end else if (w_found) begin
          w_state_next = S_STEP;
        end
      end

      S_STEP: begin
        send_enable    = 1'b1;
        valid_signal   = 1'b1;
        w_ack_cnt_next = '0;
        case (r_cmd.op)
          OP_INC: begin
            on_signal       = 1'b1;
            increase_signal = 1'b1;
            amount_signal   = w_a_eff;
            clamped         = (w_a_eff < r_cmd.amount);
            w_level_next    = r_level + w_step;
          end
          OP_DEC: begin
            on_signal       = 1'b1;
            decrease_signal = 1'b1;
            amount_signal   = w_a_eff;
            clamped         = (w_a_eff < r_cmd.amount);
            w_level_next    = r_level - w_step;
          end
          OP_OFF: begin
            off_signal = 1'b1;
          end
          default: begin
            on_signal = 1'b1;
          end
        endcase
        if (w_override) begin
          w_drop = 1'b1;
        end else if (r_cmd.op == OP_OFF) begin
          w_level_next = '0;
          w_state_next = S_OFF;
        end else begin
          w_state_next = S_ACK;
        end
      end

      S_ACK: begin
        send_enable  = 1'b1;
        valid_signal = 1'b1;
        on_signal    = 1'b1;
        if (w_override) begin
          w_drop = 1'b1;
        end else if (order) begin
          // A DEC that emptied the DAC leaves nothing to hold.
          w_state_next = (r_level == '0) ? S_OFF : S_HOLD;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_drop = 1'b1;
        end else begin
          w_ack_cnt_next = r_ack_cnt + AW'(1);
        end
      end

      default: begin
        w_state_next = S_OFF;
      end
    endcase

    if (w_drop) begin
      w_state_next = S_OFF;
      w_level_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level    <= '0;
      r_cmd      <= '0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_ack_cnt  <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_level    <= w_level_next;
      r_ack_cnt  <= w_ack_cnt_next;
      r_err_drop <= w_drop;
      if (w_found) begin
        r_cmd      <= w_sel_cmd;
        r_grant_id <= w_index;
        r_rr_ptr   <= (w_index == LAST_REQ) ? '0 : w_index + IW'(1);
      end
    end
  end

  assign req_ready = w_grant;
  assign level     = r_level;
  assign grant_id  = r_grant_id;
  assign err_drop  = r_err_drop;

endmodule
